// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with exception/interrupt entry, MRET and cycle/instret counters.
// Reads are combinational (pre-write value); all state updates on the rising clock edge.
module csr_trap_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 64,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  input  logic            inst_retire,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            mret,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic            irq_pending,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic             r_mstatus_mie;
  logic             r_mstatus_mpie;
  logic             r_mie_mtie;
  logic             r_mie_meie;
  logic [XLEN-1:0]  r_mtvec;
  logic [XLEN-1:0]  r_mscratch;
  logic [XLEN-1:0]  r_mepc;
  logic [XLEN-1:0]  r_mcause;
  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;

  logic [63:0]      w_cyc64;
  logic [63:0]      w_ins64;
  logic [XLEN-1:0]  w_rd_raw;
  logic             w_hit;
  logic             w_access;
  logic             w_is_write;
  logic [XLEN-1:0]  w_wval;
  logic [63:0]      w_wval64;
  logic [63:0]      w_cyc_lo_new;
  logic [63:0]      w_cyc_hi_new;
  logic [63:0]      w_ins_lo_new;
  logic [63:0]      w_ins_hi_new;
  logic             w_mode_vec;
  logic             w_ext;
  logic             w_tmr;
  logic [3:0]       w_irq_code;
  logic             w_take_trap;
  logic             w_take_irq;
  logic             w_take_mret;
  logic             w_do_write;
  logic [XLEN-1:0]  w_base;
  logic [XLEN-1:0]  w_epc;

  assign w_cyc64 = 64'(r_mcycle);
  assign w_ins64 = 64'(r_minstret);
  assign w_epc   = {r_mepc[XLEN-1:2], 2'b00};
  assign w_base  = {r_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    w_rd_raw = '0;
    w_hit    = 1'b1;
    case (csr_addr)
      A_MSTATUS: begin
        w_rd_raw[3] = r_mstatus_mie;
        w_rd_raw[7] = r_mstatus_mpie;
      end
      A_MIE: begin
        w_rd_raw[7]  = r_mie_mtie;
        w_rd_raw[11] = r_mie_meie;
      end
      A_MTVEC:    w_rd_raw = r_mtvec;
      A_MSCRATCH: w_rd_raw = r_mscratch;
      A_MEPC:     w_rd_raw = w_epc;
      A_MCAUSE:   w_rd_raw = r_mcause;
      A_MIP: begin
        w_rd_raw[7]  = timer_irq;
        w_rd_raw[11] = ext_irq;
      end
      A_MCYCLE:   w_rd_raw = XLEN'(w_cyc64);
      A_MINSTRET: w_rd_raw = XLEN'(w_ins64);
      A_MCYCLEH: begin
        if (XLEN == 32) w_rd_raw = XLEN'(w_cyc64[63:32]);
        else            w_hit    = 1'b0;
      end
      A_MINSTRETH: begin
        if (XLEN == 32) w_rd_raw = XLEN'(w_ins64[63:32]);
        else            w_hit    = 1'b0;
      end
      default:    w_hit = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so mip stays readable via CSRRS x0.
  assign w_access    = (csr_op[1:0] != 2'b00);
  assign w_is_write  = w_access & ((csr_op[1:0] == 2'b01) | (csr_wdata != '0));
  assign illegal_csr = w_access & (~w_hit | ((csr_addr == A_MIP) & w_is_write));
  assign csr_rdata   = illegal_csr ? '0 : w_rd_raw;

  always_comb begin
    case (csr_op[1:0])
      2'b10:   w_wval = w_rd_raw | csr_wdata;
      2'b11:   w_wval = w_rd_raw & ~csr_wdata;
      default: w_wval = csr_wdata;
    endcase
  end

  assign w_wval64     = 64'(w_wval);
  assign w_cyc_lo_new = (XLEN == 32) ? {w_cyc64[63:32], w_wval64[31:0]} : w_wval64;
  assign w_cyc_hi_new = {w_wval64[31:0], w_cyc64[31:0]};
  assign w_ins_lo_new = (XLEN == 32) ? {w_ins64[63:32], w_wval64[31:0]} : w_wval64;
  assign w_ins_hi_new = {w_wval64[31:0], w_ins64[31:0]};
  assign w_mode_vec   = (VECTORED_EN != 0) && (w_wval[1:0] == 2'b01);

  assign w_ext       = r_mstatus_mie & r_mie_meie & ext_irq;
  assign w_tmr       = r_mstatus_mie & r_mie_mtie & timer_irq;
  assign irq_pending = w_ext | w_tmr;
  assign w_irq_code  = w_ext ? 4'd11 : 4'd7;

  assign w_take_trap = trap_req;
  assign w_take_irq  = ~trap_req & irq_pending & inst_retire;
  assign w_take_mret = ~trap_req & ~w_take_irq & mret;
  assign w_do_write  = ~trap_req & ~w_take_irq & ~mret & w_is_write & ~illegal_csr;
  assign redirect    = w_take_trap | w_take_irq | w_take_mret;

  always_comb begin
    redirect_pc = '0;
    if (w_take_trap)
      redirect_pc = w_base;
    else if (w_take_irq)
      redirect_pc = r_mtvec[0] ? (w_base + XLEN'({w_irq_code, 2'b00})) : w_base;
    else if (w_take_mret)
      redirect_pc = w_epc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
    end else begin
      // Counter increments first; a CSR write to the same counter below takes precedence.
      r_mcycle <= r_mcycle + CNT_W'(1);
      if (inst_retire && !trap_req) r_minstret <= r_minstret + CNT_W'(1);

      if (w_take_trap) begin
        r_mepc         <= trap_pc;
        r_mcause       <= trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_take_irq) begin
        r_mepc         <= next_pc;
        r_mcause       <= {1'b1, (XLEN-1)'(w_irq_code)};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_take_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_do_write) begin
        case (csr_addr)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_wval[3];
            r_mstatus_mpie <= w_wval[7];
          end
          A_MIE: begin
            r_mie_mtie <= w_wval[7];
            r_mie_meie <= w_wval[11];
          end
          A_MTVEC:     r_mtvec    <= {w_wval[XLEN-1:2], 1'b0, w_mode_vec};
          A_MSCRATCH:  r_mscratch <= w_wval;
          A_MEPC:      r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          A_MCAUSE:    r_mcause   <= w_wval;
          A_MCYCLE:    r_mcycle   <= w_cyc_lo_new[CNT_W-1:0];
          A_MINSTRET:  r_minstret <= w_ins_lo_new[CNT_W-1:0];
          A_MCYCLEH:   r_mcycle   <= w_cyc_hi_new[CNT_W-1:0];
          A_MINSTRETH: r_minstret <= w_ins_hi_new[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit (XLEN=32, CNT_W=64, vectored mode enabled).
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        inst_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] next_pc;
  logic        mret;
  logic        timer_irq;
  logic        ext_irq;
  logic        irq_pending;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(32), .CNT_W(64), .VECTORED_EN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .inst_retire (inst_retire),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .next_pc     (next_pc),
    .mret        (mret),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .irq_pending (irq_pending),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data);
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_op    = 3'b000;
    csr_wdata = '0;
  endtask

  // CSRRS with a zero operand: a pure read
  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op    = 3'b010;
    csr_addr  = addr;
    csr_wdata = '0;
    #1;
    chk(tag, csr_rdata, exp);
    csr_op = 3'b000;
  endtask

  initial begin
    rst = 1'b1; csr_op = '0; csr_addr = '0; csr_wdata = '0;
    inst_retire = 0; trap_req = 0; trap_cause = '0; trap_pc = '0; next_pc = '0;
    mret = 0; timer_irq = 0; ext_irq = 0;

    // Reset state
    tick(); tick();
    rd("rst_mcycle",   12'hB00, 32'h0);
    rd("rst_mcycleh",  12'hB80, 32'h0);
    rd("rst_minstret", 12'hB02, 32'h0);
    rd("rst_mstatus",  12'h300, 32'h0);
    rd("rst_mtvec",    12'h305, 32'h0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_irq_pend", irq_pending, 1'b0);
    rst = 1'b0;
    tick();
    rd("mcycle_first", 12'hB00, 32'h1);
    rd("minstret_idle", 12'hB02, 32'h0);

    // Read-modify-write on mscratch
    wr(3'b001, 12'h340, 32'hDEADBEEF);
    csr_op = 3'b010; csr_addr = 12'h340; csr_wdata = 32'h10;
    #1;
    chk("rs_old_value", csr_rdata, 32'hDEADBEEF);
    chk("plain_redirect", redirect, 1'b0);
    tick();
    csr_op = 3'b000; csr_wdata = '0;
    rd("rs_result", 12'h340, 32'hDEADBEFF);
    wr(3'b011, 12'h340, 32'h0000000F);
    rd("rc_result", 12'h340, 32'hDEADBEF0);

    // Immediate forms and field masking on mie
    wr(3'b101, 12'h304, 32'hFFFFFFFF);
    rd("rwi_mie", 12'h304, 32'h00000880);
    wr(3'b111, 12'h304, 32'h00000080);
    rd("rci_mie", 12'h304, 32'h00000800);

    // Reserved mtvec mode collapses to direct
    wr(3'b001, 12'h305, 32'h00000103);
    rd("mtvec_mode3", 12'h305, 32'h00000100);
    wr(3'b110, 12'h305, 32'h00000001);
    rd("mtvec_vec", 12'h305, 32'h00000101);

    // Illegal accesses
    timer_irq = 1'b1;
    rd("mip_read", 12'h344, 32'h00000080);
    timer_irq = 1'b0;
    csr_op = 3'b001; csr_addr = 12'h344; csr_wdata = 32'hFFFF;
    #1;
    chk("mip_wr_illegal", illegal_csr, 1'b1);
    chk("mip_wr_rdata", csr_rdata, 32'h0);
    tick();
    csr_op = 3'b001; csr_addr = 12'h7C0; csr_wdata = 32'h1234;
    #1;
    chk("unimpl_illegal", illegal_csr, 1'b1);
    chk("unimpl_rdata", csr_rdata, 32'h0);
    tick();
    csr_op = 3'b000; csr_wdata = '0;
    rd("illegal_nochg", 12'h340, 32'hDEADBEF0);
    rd("illegal_mie", 12'h304, 32'h00000800);

    // Vectored external interrupt
    wr(3'b001, 12'h300, 32'h00000008);
    ext_irq = 1'b1;
    #1;
    chk("ext_pending", irq_pending, 1'b1);
    chk("no_retire_redir", redirect, 1'b0);
    inst_retire = 1'b1; next_pc = 32'h200;
    #1;
    chk("irq_redirect", redirect, 1'b1);
    chk("irq_vec_pc", redirect_pc, 32'h0000012C);
    tick();
    inst_retire = 1'b0;
    chk("irq_masked", irq_pending, 1'b0);
    rd("irq_mcause",   12'h342, 32'h8000000B);
    rd("irq_mepc",     12'h341, 32'h00000200);
    rd("irq_mstatus",  12'h300, 32'h00000080);
    rd("irq_minstret", 12'hB02, 32'h1);

    // MRET back
    mret = 1'b1;
    #1;
    chk("mret_redirect", redirect, 1'b1);
    chk("mret_pc", redirect_pc, 32'h00000200);
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h00000088);

    // Exception beats pending interrupt and a same-cycle CSR write
    trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h44; inst_retire = 1'b1;
    csr_op = 3'b001; csr_addr = 12'h340; csr_wdata = 32'h12345678;
    #1;
    chk("trap_redirect", redirect, 1'b1);
    chk("trap_pc", redirect_pc, 32'h00000100);
    tick();
    trap_req = 1'b0; inst_retire = 1'b0; csr_op = 3'b000; csr_wdata = '0;
    ext_irq = 1'b0;
    rd("trap_mcause",   12'h342, 32'h2);
    rd("trap_mepc",     12'h341, 32'h44);
    rd("trap_mscratch", 12'h340, 32'hDEADBEF0);
    rd("trap_minstret", 12'hB02, 32'h1);
    rd("trap_mstatus",  12'h300, 32'h00000080);

    // Timer interrupt, mepc low bits masked
    wr(3'b001, 12'h304, 32'h00000880);
    wr(3'b001, 12'h300, 32'h00000008);
    wr(3'b001, 12'h341, 32'h00000203);
    rd("mepc_masked", 12'h341, 32'h00000200);
    timer_irq = 1'b1; inst_retire = 1'b1; next_pc = 32'h300;
    #1;
    chk("tmr_vec_pc", redirect_pc, 32'h0000011C);
    tick();
    inst_retire = 1'b0; timer_irq = 1'b0;
    rd("tmr_mcause",   12'h342, 32'h80000007);
    rd("tmr_mepc",     12'h341, 32'h00000300);
    rd("tmr_minstret", 12'hB02, 32'h2);

    // Counter carry into the high half
    wr(3'b001, 12'hB80, 32'h0);
    wr(3'b001, 12'hB00, 32'hFFFFFFFF);
    tick();
    rd("mcycle_wrap",  12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);

    // Reset wins over a same-cycle trap and write
    rst = 1'b1; trap_req = 1'b1; trap_cause = 32'h5; trap_pc = 32'h88;
    csr_op = 3'b001; csr_addr = 12'h340; csr_wdata = 32'h55;
    tick();
    rst = 1'b0; trap_req = 1'b0; csr_op = 3'b000; csr_wdata = '0;
    rd("rstwin_mcause",   12'h342, 32'h0);
    rd("rstwin_mscratch", 12'h340, 32'h0);
    rd("rstwin_mepc",     12'h341, 32'h0);
    rd("rstwin_mstatus",  12'h300, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 64, width of mcycle/minstret counters; legal range 32..64.
REQ-003 SHALL have parameter VECTORED_EN, default 1; when 0, mtvec.MODE is forced to 0.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 csr_op  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 = no access.
REQ-008 csr_addr  input  12  CSR address.
REQ-009 csr_wdata  input  XLEN  rs1 value or zero-extended uimm, supplied by datapath.
REQ-010 csr_rdata  output  XLEN  combinational read of pre-write value.
REQ-011 illegal_csr  output  1  combinational; access to an unimplemented CSR or write to a read-only CSR.
REQ-012 inst_retire  input  1  one instruction retires this cycle.
REQ-013 trap_req  input  1  synchronous exception this cycle.
REQ-014 trap_cause  input  XLEN  exception code, MSB 0.
REQ-015 trap_pc  input  XLEN  PC of faulting instruction.
REQ-016 next_pc  input  XLEN  resume PC for an interrupt taken at this boundary.
REQ-017 mret  input  1  MRET executing this cycle.
REQ-018 timer_irq, ext_irq  input  1 each  level-sensitive interrupt lines.
REQ-019 irq_pending  output  1  enabled interrupt present.
REQ-020 redirect  output  1  combinational; fetch SHALL jump to redirect_pc.
REQ-021 redirect_pc  output  XLEN  target address.

Function
REQ-022 Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304 (MTIE bit 7, MEIE bit 11), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mip 0x344 (read-only, MTIP bit 7 = timer_irq, MEIP bit 11 = ext_irq), mcycle 0xB00, minstret 0xB02; for XLEN=32 additionally mcycleh 0xB80, minstreth 0xB82 (upper counter bits, zero-padded beyond CNT_W).
REQ-023 Write value: RW/RWI = wdata; RS/RSI = old | wdata; RC/RCI = old & ~wdata; unimplemented bits are discarded.
REQ-024 Unimplemented address or any write to mip: illegal_csr=1, csr_rdata=0, no state change.
REQ-025 irq_pending = mstatus.MIE & ((mie.MEIE & ext_irq) | (mie.MTIE & timer_irq)).
REQ-026 Event priority per cycle: trap_req > interrupt (irq_pending & inst_retire) > mret > CSR write; the highest-priority event suppresses all lower ones, including the CSR write.
REQ-027 Exception entry: mepc<=trap_pc, mcause<=trap_cause, MPIE<=MIE, MIE<=0; redirect=1, redirect_pc={mtvec[XLEN-1:2],2'b00}.
REQ-028 Interrupt entry: external beats timer; mcause<={1,code} with code 11 (external) or 7 (timer); mepc<=next_pc; MPIE<=MIE, MIE<=0; redirect_pc = base, plus 4*code when mtvec.MODE=1.
REQ-029 mret: MIE<=MPIE, MPIE<=1, redirect=1, redirect_pc=mepc.
REQ-030 mtvec.MODE values other than 0/1 SHALL be written as 0.
REQ-031 mcycle SHALL increment every non-reset cycle; minstret SHALL increment on inst_retire unless trap_req; both wrap at 2^CNT_W to 0.
REQ-032 A CSR write to a counter (low or high half) in the same cycle overrides that cycle's increment.
REQ-033 redirect=0 in every cycle with no trap, interrupt or mret.

Reset
REQ-034 On rst: mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle, minstret all 0; outputs follow combinationally from that state (redirect=0, irq_pending=0).
REQ-035 rst asserted in the same cycle as trap_req/mret/CSR write SHALL win; no event side effect is retained.

Verification
REQ-036 RW 0x340 wdata=0xDEADBEEF, then RS wdata=0x10 -> second read returns 0xDEADBEEF, mscratch=0xDEADBEFF.
REQ-037 mtvec=0x101 (vectored), mie=0x800, mstatus=0x8, ext_irq=1 with inst_retire, next_pc=0x200 -> redirect_pc=0x12C, mcause=0x8000000B, mepc=0x200, mstatus=0x80.
REQ-038 Then mret -> redirect_pc=0x200, mstatus=0x88.
REQ-039 trap_req with cause 2, trap_pc=0x44 plus ext_irq pending and RW to mscratch same cycle -> mcause=2, mepc=0x44, mscratch unchanged, redirect_pc=0x100.
REQ-040 Write 0x344 or read 0x7C0 -> illegal_csr=1, csr_rdata=0, no state change.
REQ-041 XLEN=32: mcycle written 0xFFFFFFFF, mcycleh 0 -> after one cycle mcycle=0, mcycleh=1; mcycleh reads 0 after rst.
